// File: rtl/down_counter_pkg.sv
// down_counter_pkg: FSM state encoding and default width shared by down_counter_load.
package down_counter_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/down_counter_load.sv
// down_counter_load: loadable down counter with IDLE/RUN/DONE FSM and one-cycle terminal-count pulse.
// Define DOWN_COUNTER_RELOAD_EN to auto-reload the last loaded value instead of stopping in DONE.
module down_counter_load
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             step;
    logic             last_step;
`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    // a pending load always beats the enabled decrement, including the 1->0 step
    assign step      = !load && en && state_q == RUN;
    assign last_step = step && count_q == WIDTH'(1);

    always_comb begin
        state_d = state_q;
        if (load)
            state_d = (data == '0) ? DONE : RUN;
        else if (last_step)
`ifdef DOWN_COUNTER_RELOAD_EN
            state_d = RUN;
`else
            state_d = DONE;
`endif
    end

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            count_d = data;
        end else if (last_step) begin
            tc_d = 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
            count_d = reload_q;
`else
            count_d = '0;
`endif
        end else if (step && count_q > WIDTH'(1)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

`ifdef DOWN_COUNTER_RELOAD_EN
    assign reload_d = (load && data != '0) ? data : reload_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            tc_q     <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tc_q     <= tc_d;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign done  = state_q == DONE;
endmodule

// File: tb/tb_down_counter_load.sv
// tb_down_counter_load: scoreboard bench; a behavioural model queues expected outputs, a monitor compares them.
module tb_down_counter_load;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data = '0;
    logic       en = 1'b0;
    logic [7:0] count;
    logic       tc;
    logic       done;

    typedef struct {
        int cnt;
        bit tc;
        bit dn;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total = 0;
    int   tc_seen = 0;

    int m_cnt = 0;
    bit m_tc = 0;
    bit m_run = 0;
    bit m_fin = 0;
    int m_rel = 0;

    down_counter_load dut (
        .clk(clk), .rst(rst), .load(load), .data(data), .en(en),
        .count(count), .tc(tc), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: counts are plain integers; running/finished flags stand in for the FSM.
    task automatic model_step(input bit r, input bit l, input int d, input bit e);
        m_tc = 0;
        if (r) begin
            m_cnt = 0; m_run = 0; m_fin = 0; m_rel = 0;
        end else if (l) begin
            m_cnt = d;
            if (d != 0) begin m_run = 1; m_fin = 0; m_rel = d; end
            else begin m_run = 0; m_fin = 1; end
        end else if (e && m_run) begin
            if (m_cnt == 1) begin
                m_tc = 1;
`ifdef DOWN_COUNTER_RELOAD_EN
                m_cnt = m_rel;
`else
                m_cnt = 0; m_run = 0; m_fin = 1;
`endif
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic cyc(input bit r, input bit l, input int d, input bit e);
        rst = r; load = l; data = 8'(d); en = e;
        model_step(r, l, d & 255, e);
        @(posedge clk);
        #1;
        sb.push_back('{m_cnt, m_tc, m_fin});
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (tc === 1'b1) tc_seen++;
            chk("count", (^count === 1'bx) ? -1 : int'(count), e.cnt);
            chk("tc", (tc === 1'bx) ? -1 : int'(tc), int'(e.tc));
            chk("done", (done === 1'bx) ? -1 : int'(done), int'(e.dn));
        end
    end

    initial begin
        int base;
        // reset overrides a simultaneous load
        cyc(1, 1, 50, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        // load 205 then count fully down
        cyc(0, 1, 205, 0);
        settle();
        base = tc_seen;
        repeat (205) cyc(0, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        settle();
        chk("tc_pulses_205", tc_seen - base, 1);
        // enable gating
        cyc(0, 1, 10, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, (i % 2) == 0);
        cyc(0, 0, 0, 1);
        // reset mid-count aborts without tc
        cyc(0, 1, 100, 0);
        repeat (30) cyc(0, 0, 0, 1);
        settle();
        base = tc_seen;
        cyc(1, 0, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        settle();
        chk("tc_after_rst", tc_seen - base, 0);
        // boundaries: zero load, full-scale load, load colliding with 1->0
        cyc(0, 1, 0, 1);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(0, 1, 255, 0);
        repeat (258) cyc(0, 0, 0, 1);
        cyc(0, 1, 2, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 7, 1);
        repeat (9) cyc(0, 0, 0, 1);
        // reload pattern (also valid without reload: stops in DONE)
        cyc(0, 1, 3, 0);
        repeat (10) cyc(0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 3);
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0, d, $urandom_range(0, 9) < 7);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/down_counter_load.md
DOWN_COUNTER_LOAD -- requirements
Module: down_counter_load

Interface
REQ-001 Parameter: WIDTH, default 8, counter and data width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  load request; captures data into count.
REQ-005 Port: data  input  WIDTH  load value.
REQ-006 Port: en  input  1  count enable; decrement permitted only while high.
REQ-007 Port: count  output  WIDTH  current counter value, registered.
REQ-008 Port: tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-009 Port: done  output  1  level flag; high while the FSM is in DONE.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 Priority at each rising edge SHALL be: rst > load > en > hold.
REQ-012 In any state, load=1 with data!=0 SHALL set count<=data, store data in an internal reload register, and go to RUN.
REQ-013 In any state, load=1 with data==0 SHALL set count<=0, go to DONE, and leave tc low.
REQ-014 In RUN with en=1 and count>1, count SHALL decrement by 1 per cycle.
REQ-015 In RUN with en=1 and count==1, count SHALL become 0, tc SHALL be high for the following cycle only, and the FSM SHALL go to DONE (reload behaviour in REQ-026).
REQ-016 In RUN with en=0, count SHALL hold and tc SHALL be low.
REQ-017 In IDLE, count SHALL hold at 0 regardless of en; only load leaves IDLE.
REQ-018 In DONE, count SHALL hold at 0, done SHALL be 1, and en SHALL be ignored; count never wraps to all-ones.
REQ-019 load asserted in the same cycle as the 1->0 transition SHALL win: count<=data and tc stays low.
REQ-020 Decrement arithmetic SHALL be WIDTH bits unsigned; a loaded value of 2^WIDTH-1 SHALL count down fully with no overflow.
REQ-021 Load latency SHALL be one cycle: count reflects data on the edge where load=1 is sampled.

Reset
REQ-022 On rst=1 at a rising edge: count=0, tc=0, done=0, reload register=0, FSM=IDLE.
REQ-023 rst SHALL override load and en in the same cycle.
REQ-024 rst asserted mid-count SHALL abort the count with no tc pulse.

Configuration
REQ-025 Macro DOWN_COUNTER_RELOAD_EN SHALL compile the auto-reload feature in or out.
REQ-026 With DOWN_COUNTER_RELOAD_EN defined, the 1->0 step of REQ-015 SHALL instead set count<=reload register, pulse tc for one cycle, and remain in RUN; DONE is then reachable only via REQ-013.
REQ-027 Without DOWN_COUNTER_RELOAD_EN, the reload register SHALL NOT be synthesised and REQ-015 applies as written.

Structure
REQ-028 A package down_counter_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 The block SHALL be a single module; no sub-module is needed.
REQ-030 FSM next-state logic and the count datapath SHALL be kept in separate always blocks.

Verification
REQ-031 Reset: rst=1 for 1 cycle, load=1 data=8'd50 in the same cycle -> count=0, FSM IDLE, done=0, tc=0.
REQ-032 Load and count: load=1 data=8'd205 for 1 cycle, then en=1 -> count=205, 204, ..., 1, 0 after 205 enabled cycles; tc high for exactly 1 cycle; done=1 and count holds at 0 afterwards.
REQ-033 Enable gating: load 8'd10, en toggled 1/0 each cycle -> count decrements only on en=1 cycles; reaches 0 after 20 cycles.
REQ-034 Reset mid-count: load 8'd100, 30 enabled cycles (count=70), then rst=1 -> count=0, IDLE, no tc pulse.
REQ-035 Boundary cases: load data=0 -> DONE immediately, tc stays low. Load 8'd255 -> counts to 0 with no wrap. load=1 data=8'd7 on the cycle count goes 1->0 -> count=7, tc low.
REQ-036 Reload (DOWN_COUNTER_RELOAD_EN defined): load 8'd3, en=1 -> count sequence 3, 2, 1, 3, 2, 1, ... with one tc pulse every 3 cycles; done stays 0.
